// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: the bubble values and
// the per-stage control/payload bundles used to size each stage instance.
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       reg_write;
    logic       mem_to_reg;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       reg_write;
    logic       mem_to_reg;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_data_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rd_addr;
    logic [26:0] rsvd;
  } ex_mem_data_t;

  localparam ex_mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One register slot of a pipeline stage: valid bit plus ctrl/inst/data.
// clear has priority over load; the payload is only written on load.
module pipe_entry #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [31:0]       d_inst,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [31:0]       q_inst,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload needs no reset: it is masked downstream whenever valid is low.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      q_ctrl <= d_ctrl;
      q_inst <= d_inst;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush,
// optional two-entry skid buffer and bubble forcing on the outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          CTRL_W   = $bits(pipe_pkg::ex_mem_ctrl_t),
  parameter int          DATA_W   = $bits(pipe_pkg::ex_mem_data_t),
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST,
  parameter int          SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A presented entry holds steady until it is accepted or flushed.
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [31:0]       m_inst;
  logic [DATA_W-1:0] m_data;
  logic              in_fire;
  logic              out_fire;
  logic [31:0]       stall_cnt_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = m_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              s_valid;
      logic [CTRL_W-1:0] s_ctrl;
      logic [31:0]       s_inst;
      logic [DATA_W-1:0] s_data;
      logic              s_to_m;
      logic              m_load;
      logic              s_load;
      logic [CTRL_W-1:0] m_d_ctrl;
      logic [31:0]       m_d_inst;
      logic [DATA_W-1:0] m_d_data;

      // in_ready comes straight from a flop, so no path from out_ready.
      assign in_ready = !s_valid;
      assign s_to_m   = out_fire && s_valid;
      assign m_load   = (in_fire && (!m_valid || out_fire)) || s_to_m;
      assign s_load   = in_fire && m_valid && !out_fire;

      // While S is full nothing is accepted, so S is the only M source then.
      assign m_d_ctrl = s_valid ? s_ctrl : in_ctrl;
      assign m_d_inst = s_valid ? s_inst : in_inst;
      assign m_d_data = s_valid ? s_data : in_data;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
        .clk    (clk),
        .rst    (rst),
        .load   (m_load),
        .clear  (flush || (out_fire && !m_load)),
        .d_ctrl (m_d_ctrl),
        .d_inst (m_d_inst),
        .d_data (m_d_data),
        .valid  (m_valid),
        .q_ctrl (m_ctrl),
        .q_inst (m_inst),
        .q_data (m_data)
      );

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s (
        .clk    (clk),
        .rst    (rst),
        .load   (s_load),
        .clear  (flush || s_to_m),
        .d_ctrl (in_ctrl),
        .d_inst (in_inst),
        .d_data (in_data),
        .valid  (s_valid),
        .q_ctrl (s_ctrl),
        .q_inst (s_inst),
        .q_data (s_data)
      );
    end else begin : g_single
      assign in_ready = !m_valid || out_ready;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
        .clk    (clk),
        .rst    (rst),
        .load   (in_fire),
        .clear  (flush || (out_fire && !in_fire)),
        .d_ctrl (in_ctrl),
        .d_inst (in_inst),
        .d_data (in_data),
        .valid  (m_valid),
        .q_ctrl (m_ctrl),
        .q_inst (m_inst),
        .q_data (m_data)
      );
    end
  endgenerate

  // Stalls keep counting through a flush; only reset clears the counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (m_valid && !out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : CTRL_W'(CTRL_BUBBLE);
  assign out_inst  = m_valid ? m_inst : NOP_INST;
  assign out_data  = m_valid ? m_data : '0;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one single-entry
// instance share the stimulus; each section checks the instance it targets.
module tb_pipe_stage_reg;

  localparam int          CW  = 6;
  localparam int          DW  = 192;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [31:0]   in_inst;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [31:0]   out_inst1, out_inst0, stall_cnt1, stall_cnt0;
  logic [DW-1:0] out_data1, out_data0;

  int checks;
  int errors;

  pipe_stage_reg #(.SKID(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_inst(in_inst), .in_data(in_data), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_inst(out_inst1), .out_data(out_data1), .stall_cnt(stall_cnt1)
  );

  pipe_stage_reg #(.SKID(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_inst(in_inst), .in_data(in_data), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
    .out_inst(out_inst0), .out_data(out_data0), .stall_cnt(stall_cnt0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    in_ctrl  = inst[CW-1:0];
    in_data  = {6{inst}};
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_inst   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    // 1: fill the stage, then reset it while full
    rst = 1'b1;
    offer(32'h000000AA);
    step();
    idle();
    chk("pre_rst_valid", out_valid1, 1'b1);
    chk("pre_rst_inst", out_inst1, 32'h000000AA);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_valid", out_valid1, 1'b0);
    chk("rst_inst", out_inst1, NOP);
    chk("rst_ctrl", out_ctrl1, '0);
    chk("rst_data", out_data1, '0);
    chk("rst_in_ready", in_ready1, 1'b1);
    chk("rst_stall", stall_cnt1, 32'd0);
    chk("rst_valid_s0", out_valid0, 1'b0);
    chk("rst_inst_s0", out_inst0, NOP);

    // 2: stream 1..8 through the skid stage with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("stream_in_ready", in_ready1, 1'b1);
      offer(32'(i));
      step();
      chk("stream_valid", out_valid1, 1'b1);
      chk("stream_inst", out_inst1, 32'(i));
    end
    chk("stream_ctrl", out_ctrl1, 6'd8);
    chk("stream_data", out_data1, {6{32'd8}});
    idle();
    step();
    chk("stream_end_valid", out_valid1, 1'b0);
    chk("stream_stall", stall_cnt1, 32'd0);

    // 3: back-pressure fills M then S; release drains in order
    out_ready = 1'b0;
    offer(32'h000000A1);
    step();
    chk("bp_a_inst", out_inst1, 32'h000000A1);
    chk("bp_a_in_ready", in_ready1, 1'b1);
    offer(32'h000000B2);
    step();
    idle();
    chk("bp_full_in_ready", in_ready1, 1'b0);
    chk("bp_full_inst", out_inst1, 32'h000000A1);
    chk("bp_stall_1", stall_cnt1, 32'd1);
    step();
    chk("bp_hold_inst", out_inst1, 32'h000000A1);
    chk("bp_stall_2", stall_cnt1, 32'd2);
    out_ready = 1'b1;
    step();
    chk("bp_b_inst", out_inst1, 32'h000000B2);
    chk("bp_b_valid", out_valid1, 1'b1);
    chk("bp_drained_in_ready", in_ready1, 1'b1);
    step();
    chk("bp_empty_valid", out_valid1, 1'b0);
    chk("bp_stall_final", stall_cnt1, 32'd2);

    // 4: flush with M and S full while C is offered
    out_ready = 1'b0;
    offer(32'h000000C1);
    step();
    offer(32'h000000C2);
    step();
    chk("fl_full_in_ready", in_ready1, 1'b0);
    offer(32'h000000CC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("fl_valid", out_valid1, 1'b0);
    chk("fl_inst", out_inst1, NOP);
    chk("fl_in_ready", in_ready1, 1'b1);
    chk("fl_stall_kept", stall_cnt1, 32'd4);
    step();
    chk("fl_no_c_valid", out_valid1, 1'b0);
    chk("fl_no_c_inst", out_inst1, NOP);

    // 5: single-entry stage replaces M in the same cycle it drains
    rst = 1'b0;
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    offer(32'h000000D0);
    step();
    chk("s0_d0_inst", out_inst0, 32'h000000D0);
    offer(32'h000000D1);
    #1;
    chk("s0_full_in_ready", in_ready0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("s0_comb_in_ready", in_ready0, 1'b1);
    step();
    idle();
    chk("s0_d1_valid", out_valid0, 1'b1);
    chk("s0_d1_inst", out_inst0, 32'h000000D1);
    step();
    chk("s0_empty_valid", out_valid0, 1'b0);
    chk("s1_after_s0_stall", stall_cnt1, 32'd0);

    // 6: stall counter wrap, with a flush in the third stalled cycle
    out_ready = 1'b0;
    offer(32'h000000F0);
    step();
    idle();
    force u1.stall_cnt_q = 32'hFFFFFFFE;
    #1;
    release u1.stall_cnt_q;
    chk("wrap_preset", stall_cnt1, 32'hFFFFFFFE);
    step();
    chk("wrap_ffff", stall_cnt1, 32'hFFFFFFFF);
    step();
    chk("wrap_zero", stall_cnt1, 32'h00000000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("wrap_one", stall_cnt1, 32'h00000001);
    chk("wrap_flush_valid", out_valid1, 1'b0);
    step();
    chk("wrap_hold", stall_cnt1, 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register, successor to the fixed EX/MEM latch. It carries a control field, an instruction word and a generic data payload with a valid/ready handshake, flush, and an optional two-entry skid buffer. When empty it presents a canonical bubble (control 0, NOP instruction, data 0), so downstream stages never need a separate valid decode for writeback/memory enables. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB in the next core revision.

Parameters:
CTRL_W, 6, width of the packed M/WB control field.
DATA_W, 192, width of the packed payload (alu result, rs2 data, imm, pc values, rd addr, ...).
NOP_INST, 32'h00000013, instruction word presented while holding a bubble (addi x0,x0,0).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low: sampled on rising clk, state cleared when rst==0.
in_valid  in  1  upstream holds a valid entry.
in_ready  out  1  stage can accept this cycle.
in_ctrl  in  CTRL_W  control field.
in_inst  in  32  instruction word.
in_data  in  DATA_W  payload.
flush  in  1  discard all held entries and any entry offered this cycle.
out_valid  out  1  stage presents a valid entry.
out_ready  in  1  downstream accepts this cycle.
out_ctrl  out  CTRL_W  control field; 0 when out_valid==0.
out_inst  out  32  instruction; NOP_INST when out_valid==0.
out_data  out  DATA_W  payload; 0 when out_valid==0.
stall_cnt  out  32  count of cycles with out_valid && !out_ready.

Behaviour:
- Handshake: transfer occurs on an edge where valid && ready. A valid entry stays stable until it is accepted or flushed. in_valid may drop without an accept.
- Reset (rst==0 at edge): both entries are emptied, stall_cnt=0. After the edge: out_valid=0, out_ctrl=0, out_inst=NOP_INST, out_data=0, in_ready=1. Reset overrides flush and all handshakes.
- SKID=1, with main entry M and skid entry S:
  - in_ready = !S.valid, registered (no combinational path from out_ready).
  - Output always shows M.
  - Accept with M empty, or with M draining this cycle and S empty: the entry loads into M.
  - Accept with M full and not draining: the entry loads into S and in_ready falls the next cycle.
  - Drain of M with S full: S moves to M and S empties. An accept in that cycle is impossible because in_ready==0.
  - Latency: in->out 1 cycle; throughput 1 per cycle with no bubble under out_ready toggling.
- SKID=0:
  - in_ready = !M.valid || out_ready (combinational).
  - Drain and accept in the same cycle: M is replaced with the new entry with no gap.
- Flush (flush==1, rst==1): M and S are emptied at the edge. An offered entry is not captured, though in_ready may still show 1. The next cycle outputs a bubble.
  - Flush and drain in the same cycle: downstream's accept of the current M is valid; only the state after the edge is emptied.
- Bubble forcing: out_ctrl, out_inst and out_data are muxed to bubble values whenever out_valid==0. Stale payload is never visible.
- stall_cnt: increments by 1 per stalled cycle and wraps 32'hFFFFFFFF -> 0. Flush does not clear it.
- Empty-state invariants: S.valid implies M.valid. With S full the stage never accepts, so there is no overflow. An empty stage with out_ready high is legal and does nothing.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INST constant.
  - Bubble control value CTRL_BUBBLE = '0.
  - Packed struct typedefs for each stage's ctrl/data bundle, so instantiations size CTRL_W/DATA_W via $bits.
- One natural sub-module: pipe_entry (valid bit plus ctrl/inst/data register with load/clear). It is instantiated twice for M and S, and once when SKID=0.

Test Plan:
1. Reset with rst=0 while the stage is full, then rst=1 -> out_valid=0, out_inst=32'h00000013, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
2. SKID=1 streaming of 8 entries, inst=1..8, with out_ready=1 -> out_inst 1..8 on consecutive cycles, first appearing 1 cycle after accept, no gaps.
3. SKID=1 with out_ready=0 and two entries A, B offered -> A in M, B in S, in_ready=0 the following cycle. Raise out_ready -> A, then B, in order. in_ready=1 after S drains. stall_cnt reflects the stalled cycles exactly.
4. Flush with M and S full, asserted in the same cycle as in_valid=1 with entry C -> next cycle out_valid=0, out_inst=NOP. C never appears.
5. SKID=0 with M full and out_ready=1 while entry D is offered -> in_ready=1 combinationally, D on the output the next cycle, no bubble.
6. stall_cnt forced near 32'hFFFFFFFE, then stall for 3 cycles -> value wraps to 32'h00000001. A flush during the stall leaves the count unchanged.
